// File: rtl/ym_ch_mixer.sv
// ym_ch_mixer: six-slot channel mixer for a YM-style FM core.
//
// Each accepted sample (c1 & ch_valid) is converted from offset binary to signed, routed to
// the left/right sides by pan_l/pan_r, and summed into 12-bit signed accumulators over a
// six-slot frame. The slot-5 sample completes the frame: the sums are latched into
// out_l/out_r and out_valid is raised on that same edge. A consumer takes the frame with
// out_valid & out_ready.
//
// Ports:
//   MCLK       in   1   sole clock, rising edge
//   reset      in   1   asynchronous active-high reset
//   c1         in   1   phase enable; samples are accepted only on c1 edges
//   ch_out     in   9   channel sample, offset binary (0x100 = 0)
//   ch_valid   in   1   ch_out/pan valid this c1 step
//   ch_sync    in   1   accepted sample is channel 1 of a frame
//   pan_l      in   1   route sample to left
//   pan_r      in   1   route sample to right
//   out_l      out  12  signed left frame sum
//   out_r      out  12  signed right frame sum
//   out_valid  out  1   frame sums available
//   out_ready  in   1   consumer takes the frame when out_valid is high
//   overrun    out  1   sticky: a frame was latched over an unconsumed one
//   frame_err  out  1   sticky: ch_sync seen mid-frame
//
// Build option: define YM_CH_MIXER_LADDER_EN to model the YM2612 DAC ladder offset, which
// pushes every side contribution 4 further away from zero (even for muted sides).

module ym_ch_mixer (
  input  logic        MCLK,
  input  logic        reset,
  input  logic        c1,
  input  logic [8:0]  ch_out,
  input  logic        ch_valid,
  input  logic        ch_sync,
  input  logic        pan_l,
  input  logic        pan_r,
  output logic [11:0] out_l,
  output logic [11:0] out_r,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        overrun,
  output logic        frame_err
);

  localparam logic [2:0] FirstSlot = 3'd0;
  localparam logic [2:0] LastSlot  = 3'd5;

  logic               accept;
  logic               sample_neg;
  logic signed [11:0] sample_ext;
  logic signed [11:0] contrib_l;
  logic signed [11:0] contrib_r;
  logic signed [11:0] sum_l;
  logic signed [11:0] sum_r;
  logic [2:0]         eff_slot;

  logic [2:0]         slot_q, slot_d;
  logic signed [11:0] acc_l_q, acc_l_d;
  logic signed [11:0] acc_r_q, acc_r_d;
  logic signed [11:0] out_l_q, out_l_d;
  logic signed [11:0] out_r_q, out_r_d;
  logic               out_valid_q, out_valid_d;
  logic               overrun_q, overrun_d;
  logic               frame_err_q, frame_err_d;

  assign accept = c1 & ch_valid;

  // Offset binary to two's complement: invert the MSB, then sign-extend to 12 bits.
  assign sample_neg = ~ch_out[8];
  assign sample_ext = {{3{sample_neg}}, sample_neg, ch_out[7:0]};

  // Per-side contribution.
  always_comb begin
    contrib_l = pan_l ? sample_ext : 12'sd0;
    contrib_r = pan_r ? sample_ext : 12'sd0;
`ifdef YM_CH_MIXER_LADDER_EN
    // Ladder offset follows the sign of the sample, not of the (possibly muted) output.
    if (sample_neg) begin
      contrib_l = contrib_l - 12'sd4;
      contrib_r = contrib_r - 12'sd4;
    end else begin
      contrib_l = contrib_l + 12'sd4;
      contrib_r = contrib_r + 12'sd4;
    end
`endif
  end

  // Worst case is 6 x 260 = 1560 in magnitude, so 12-bit sums never wrap.
  assign sum_l = acc_l_q + contrib_l;
  assign sum_r = acc_r_q + contrib_r;

  // Next-state logic.
  always_comb begin
    slot_d      = slot_q;
    acc_l_d     = acc_l_q;
    acc_r_d     = acc_r_q;
    out_l_d     = out_l_q;
    out_r_d     = out_r_q;
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;
    // Handshake runs on every edge, independent of c1.
    out_valid_d = out_valid_q & ~out_ready;
    // A sync always restarts the frame at slot 0.
    eff_slot    = ch_sync ? FirstSlot : slot_q;

    if (accept) begin
      if (ch_sync && (slot_q != FirstSlot)) begin
        frame_err_d = 1'b1;
      end

      slot_d = (eff_slot == LastSlot) ? FirstSlot : eff_slot + 3'd1;

      if (eff_slot == FirstSlot) begin
        // Loading (not adding) drops any partial sum left by a re-sync.
        acc_l_d = contrib_l;
        acc_r_d = contrib_r;
      end else if (eff_slot == LastSlot) begin
        out_l_d     = sum_l;
        out_r_d     = sum_r;
        // A latch wins over a same-edge handshake: out_valid stays high with new data.
        out_valid_d = 1'b1;
        if (out_valid_q && !out_ready) begin
          overrun_d = 1'b1;
        end
      end else begin
        acc_l_d = sum_l;
        acc_r_d = sum_r;
      end
    end
  end

  always_ff @(posedge MCLK or posedge reset) begin
    if (reset) begin
      slot_q      <= FirstSlot;
      acc_l_q     <= '0;
      acc_r_q     <= '0;
      out_l_q     <= '0;
      out_r_q     <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      slot_q      <= slot_d;
      acc_l_q     <= acc_l_d;
      acc_r_q     <= acc_r_d;
      out_l_q     <= out_l_d;
      out_r_q     <= out_r_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign out_l     = out_l_q;
  assign out_r     = out_r_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ym_ch_mixer.sv
// Directed self-checking bench for ym_ch_mixer. Expected values are hand-computed for both
// the default build and the YM_CH_MIXER_LADDER_EN build.

module tb_ym_ch_mixer;

  logic        MCLK = 1'b0;
  logic        reset;
  logic        c1;
  logic [8:0]  ch_out;
  logic        ch_valid;
  logic        ch_sync;
  logic        pan_l;
  logic        pan_r;
  logic [11:0] out_l;
  logic [11:0] out_r;
  logic        out_valid;
  logic        out_ready;
  logic        overrun;
  logic        frame_err;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef YM_CH_MIXER_LADDER_EN
  localparam logic [11:0] EMax  = 12'h612;  // 6 x 259
  localparam logic [11:0] EMinL = 12'h9E8;  // 6 x -260
  localparam logic [11:0] EMinR = 12'hFE8;  // 6 x -4
  localparam logic [11:0] EMixL = 12'h00D;  // 132-132+4+4+9-4
  localparam logic [11:0] EMixR = 12'h18B;  // 132-4+259+4+9-5
  localparam logic [11:0] ESix  = 12'h01E;  // 6 x 5
  localparam logic [11:0] EA    = 12'h078;  // 6 x 20
  localparam logic [11:0] EBL   = 12'hF88;  // 6 x -20
  localparam logic [11:0] EBR   = 12'hFE8;  // 6 x -4
  localparam logic [11:0] EZero = 12'h018;  // 6 x 4
`else
  localparam logic [11:0] EMax  = 12'h5FA;  // 6 x 255
  localparam logic [11:0] EMinL = 12'hA00;  // 6 x -256
  localparam logic [11:0] EMinR = 12'h000;
  localparam logic [11:0] EMixL = 12'h005;  // 128-128+0+5
  localparam logic [11:0] EMixR = 12'h183;  // 128+255+0+5-1
  localparam logic [11:0] ESix  = 12'h006;  // 6 x 1
  localparam logic [11:0] EA    = 12'h060;  // 6 x 16
  localparam logic [11:0] EBL   = 12'hFA0;  // 6 x -16
  localparam logic [11:0] EBR   = 12'h000;
  localparam logic [11:0] EZero = 12'h000;
`endif

  ym_ch_mixer dut (
    .MCLK      (MCLK),
    .reset     (reset),
    .c1        (c1),
    .ch_out    (ch_out),
    .ch_valid  (ch_valid),
    .ch_sync   (ch_sync),
    .pan_l     (pan_l),
    .pan_r     (pan_r),
    .out_l     (out_l),
    .out_r     (out_r),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun),
    .frame_err (frame_err)
  );

  always #5 MCLK = ~MCLK;

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %03h expected %03h", tag, obs, exp);
    end
  endtask

  // One accepted sample; returns 1 time unit after the capturing edge.
  task automatic put(input logic [8:0] d, input logic s, input logic pl, input logic pr);
    c1 = 1'b1; ch_valid = 1'b1; ch_out = d; ch_sync = s; pan_l = pl; pan_r = pr;
    @(posedge MCLK); #1;
    c1 = 1'b0; ch_valid = 1'b0; ch_sync = 1'b0;
  endtask

  task automatic idle();
    @(posedge MCLK); #1;
  endtask

  initial begin
    reset = 1'b1; c1 = 1'b0; ch_out = 9'h100; ch_valid = 1'b0; ch_sync = 1'b0;
    pan_l = 1'b0; pan_r = 1'b0; out_ready = 1'b1;
    idle(); idle();
    chk("rst_out_l", out_l, 12'h000);
    chk("rst_out_r", out_r, 12'h000);
    chk("rst_valid", {11'd0, out_valid}, 12'h000);
    chk("rst_flags", {10'd0, overrun, frame_err}, 12'h000);
    @(negedge MCLK); reset = 1'b0;
    idle();

    // Full-scale positive frame, with non-accept edges mixed in.
    put(9'h1FF, 1'b1, 1'b1, 1'b1);
    put(9'h1FF, 1'b0, 1'b1, 1'b1);
    c1 = 1'b0; ch_valid = 1'b1; ch_sync = 1'b1; ch_out = 9'h000;
    idle();
    c1 = 1'b1; ch_valid = 1'b0;
    idle();
    c1 = 1'b0; ch_sync = 1'b0;
    for (int i = 0; i < 3; i++) put(9'h1FF, 1'b0, 1'b1, 1'b1);
    chk("max_pre_valid", {11'd0, out_valid}, 12'h000);
    put(9'h1FF, 1'b0, 1'b1, 1'b1);
    chk("max_valid", {11'd0, out_valid}, 12'h001);
    chk("max_out_l", out_l, EMax);
    chk("max_out_r", out_r, EMax);
    chk("max_no_ferr", {11'd0, frame_err}, 12'h000);
    idle();
    chk("max_pulse_end", {11'd0, out_valid}, 12'h000);
    chk("max_hold_l", out_l, EMax);

    // Full-scale negative, left only; held because out_ready is low.
    out_ready = 1'b0;
    put(9'h000, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) put(9'h000, 1'b0, 1'b1, 1'b0);
    chk("min_out_l", out_l, EMinL);
    chk("min_out_r", out_r, EMinR);
    chk("min_valid", {11'd0, out_valid}, 12'h001);

    // Mixed samples/pans, no sync (relies on the 5->0 wrap); latch meets handshake.
    put(9'h180, 1'b0, 1'b1, 1'b1);
    put(9'h080, 1'b0, 1'b1, 1'b0);
    put(9'h1FF, 1'b0, 1'b0, 1'b1);
    put(9'h100, 1'b0, 1'b1, 1'b1);
    put(9'h105, 1'b0, 1'b1, 1'b1);
    chk("mix_hold_valid", {11'd0, out_valid}, 12'h001);
    chk("mix_hold_l", out_l, EMinL);
    out_ready = 1'b1;
    put(9'h0FF, 1'b0, 1'b0, 1'b1);
    chk("mix_valid_kept", {11'd0, out_valid}, 12'h001);
    chk("mix_out_l", out_l, EMixL);
    chk("mix_out_r", out_r, EMixR);
    chk("mix_no_overrun", {11'd0, overrun}, 12'h000);
    idle();
    chk("mix_taken", {11'd0, out_valid}, 12'h000);

    // Re-sync at slot 3.
    for (int i = 0; i < 3; i++) put(9'h1FF, (i == 0), 1'b1, 1'b1);
    chk("ferr_before", {11'd0, frame_err}, 12'h000);
    put(9'h101, 1'b1, 1'b1, 1'b1);
    chk("ferr_set", {11'd0, frame_err}, 12'h001);
    for (int i = 0; i < 4; i++) put(9'h101, 1'b0, 1'b1, 1'b1);
    chk("resync_no_early", {11'd0, out_valid}, 12'h000);
    put(9'h101, 1'b0, 1'b1, 1'b1);
    chk("resync_valid", {11'd0, out_valid}, 12'h001);
    chk("resync_out_l", out_l, ESix);
    chk("resync_out_r", out_r, ESix);
    idle();

    // Two frames with out_ready low.
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) put(9'h110, (i == 0), 1'b1, 1'b1);
    chk("ovr_a_l", out_l, EA);
    chk("ovr_a_none", {11'd0, overrun}, 12'h000);
    for (int i = 0; i < 6; i++) put(9'h0F0, 1'b0, 1'b1, 1'b0);
    chk("ovr_set", {11'd0, overrun}, 12'h001);
    chk("ovr_b_l", out_l, EBL);
    chk("ovr_b_r", out_r, EBR);
    idle(); idle();
    chk("ovr_valid_held", {11'd0, out_valid}, 12'h001);
    out_ready = 1'b1;
    idle();
    chk("ovr_taken", {11'd0, out_valid}, 12'h000);
    chk("ovr_hold_l", out_l, EBL);
    chk("flags_sticky", {10'd0, overrun, frame_err}, 12'h003);

    // Muted sides at midscale (ladder offset only).
    for (int i = 0; i < 6; i++) put(9'h100, (i == 0), 1'b0, 1'b0);
    chk("zero_out_l", out_l, EZero);
    chk("zero_out_r", out_r, EZero);
    idle();

    // Reset after slot 2, then a sync-less frame.
    for (int i = 0; i < 3; i++) put(9'h1FF, (i == 0), 1'b1, 1'b1);
    out_ready = 1'b0;
    reset = 1'b1;
    #1;
    chk("async_rst_l", out_l, 12'h000);
    chk("async_rst_r", out_r, 12'h000);
    chk("async_rst_flags", {9'd0, out_valid, overrun, frame_err}, 12'h000);
    @(negedge MCLK); reset = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) put(9'h101, 1'b0, 1'b1, 1'b1);
    chk("post_rst_no_early", {11'd0, out_valid}, 12'h000);
    put(9'h101, 1'b0, 1'b1, 1'b1);
    chk("post_rst_valid", {11'd0, out_valid}, 12'h001);
    chk("post_rst_l", out_l, ESix);
    chk("post_rst_r", out_r, ESix);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
